// File: rtl/keypad_code_collector_pkg.sv
// rtl/keypad_code_collector_pkg.sv - shared key codes, FSM states and helpers for the parking keypad
package keypad_code_collector_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FULL    = 2'd2,
        ISSUE   = 2'd3
    } state_t;

    localparam logic [3:0] KEY_CLEAR  = 4'hC;
    localparam logic [3:0] KEY_ENTER  = 4'hE;
    localparam logic [2:0] PIN_DIGITS = 3'd4;

    function automatic logic is_digit(input logic [3:0] k);
        return (k <= 4'h9);
    endfunction

    function automatic logic is_live_key(input logic [3:0] k);
        return is_digit(k) || (k == KEY_CLEAR) || (k == KEY_ENTER);
    endfunction

endpackage

// File: rtl/keypad_code_collector_entry_timer.sv
// rtl/keypad_code_collector_entry_timer.sv - idle timer that expires a stalled partial PIN entry
module entry_timer #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    logic [15:0] count;

    // Holding at the terminal value keeps expired asserted until the owner clears it.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= 16'd0;
        end else if (run && !expired) begin
            count <= count + 16'd1;
        end
    end

    assign expired = run && (count == (TIMEOUT_CYCLES - 16'd1));

endmodule

// File: rtl/keypad_code_collector.sv
// rtl/keypad_code_collector.sv - gathers four keypad digits into a BCD PIN and hands it to the gate controller
module keypad_code_collector
    import keypad_code_collector_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        entry_en,
    input  logic        key_valid,
    input  logic [3:0]  key,
    output logic [15:0] code,
    output logic        code_ack,
    output logic [2:0]  digit_count,
    output logic        entry_error
);

    state_t      state, state_next;
    logic [15:0] shift, shift_next;
    logic [2:0]  count, count_next;
    logic [15:0] code_next;
    logic        ack_next;
    logic        err_next;
    logic        key_live;
    logic        timer_clear;
    logic        timer_run;
    logic        timer_expired;

    assign timer_run = (state == COLLECT) || (state == FULL);

    entry_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_entry_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .run     (timer_run),
        .expired (timer_expired)
    );

    always_comb begin
        state_next  = state;
        shift_next  = shift;
        count_next  = count;
        code_next   = code;
        ack_next    = 1'b0;
        err_next    = 1'b0;
        timer_clear = 1'b0;
        key_live    = key_valid && is_live_key(key);

        if (!entry_en) begin
            state_next  = IDLE;
            shift_next  = 16'h0000;
            count_next  = 3'd0;
            timer_clear = 1'b1;
        end else if (state == ISSUE) begin
            state_next  = IDLE;
            shift_next  = 16'h0000;
            count_next  = 3'd0;
            timer_clear = 1'b1;
        end else if (key_live) begin
            timer_clear = 1'b1;
            if (key == KEY_CLEAR) begin
                state_next = IDLE;
                shift_next = 16'h0000;
                count_next = 3'd0;
            end else if (key == KEY_ENTER) begin
                if (state == FULL) begin
                    code_next  = shift;
                    ack_next   = 1'b1;
                    state_next = ISSUE;
                end else begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                    shift_next = 16'h0000;
                    count_next = 3'd0;
                end
            end else if (state == FULL) begin
                // A fifth digit is refused but the four already held stay valid.
                err_next = 1'b1;
            end else begin
                shift_next = {shift[11:0], key};
                count_next = count + 3'd1;
                state_next = (count_next == PIN_DIGITS) ? FULL : COLLECT;
            end
        end else if (timer_expired) begin
            err_next    = 1'b1;
            state_next  = IDLE;
            shift_next  = 16'h0000;
            count_next  = 3'd0;
            timer_clear = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            shift       <= 16'h0000;
            count       <= 3'd0;
            code        <= 16'h0000;
            code_ack    <= 1'b0;
            entry_error <= 1'b0;
        end else begin
            state       <= state_next;
            shift       <= shift_next;
            count       <= count_next;
            code        <= code_next;
            code_ack    <= ack_next;
            entry_error <= err_next;
        end
    end

    assign digit_count = count;

endmodule

// File: tb/tb_keypad_code_collector.sv
// tb/tb_keypad_code_collector.sv - directed scoreboard bench for keypad_code_collector
module tb_keypad_code_collector;

    typedef struct packed {
        logic        is_ack;
        logic [15:0] code;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        entry_en;
    logic        key_valid;
    logic [3:0]  key;
    logic [15:0] code;
    logic        code_ack;
    logic [2:0]  digit_count;
    logic        entry_error;

    int          vectors = 0;
    int          miscompares = 0;
    ev_t         expq[$];
    logic [15:0] last_code = 16'h0000;
    int          got;

    keypad_code_collector #(
        .TIMEOUT_CYCLES(16'd8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .entry_en    (entry_en),
        .key_valid   (key_valid),
        .key         (key),
        .code        (code),
        .code_ack    (code_ack),
        .digit_count (digit_count),
        .entry_error (entry_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every ack/error pulse must match the oldest expectation pushed by the stimulus.
    always @(negedge clk) begin
        ev_t e;
        if (!rst && (code_ack || entry_error)) begin
            check("ack_err_exclusive", 32'(code_ack && entry_error), 32'd0);
            if (expq.size() == 0) begin
                check("unexpected_pulse", 32'({code_ack, entry_error}), 32'd0);
            end else begin
                e = expq.pop_front();
                check("pulse_kind", 32'(code_ack), 32'(e.is_ack));
                check("code_value", 32'(code), 32'(e.code));
            end
        end
    end

    // Drives one key strobe from a negedge; outputs are checked one clock after the strobe.
    task automatic press(input string tag, input logic [3:0] k, input logic exp_ack,
                         input logic exp_err, input logic [2:0] exp_cnt, input logic [15:0] exp_code);
        key       = k;
        key_valid = 1'b1;
        if (exp_ack) begin
            expq.push_back({1'b1, exp_code});
            last_code = exp_code;
        end else if (exp_err) begin
            expq.push_back({1'b0, last_code});
        end
        @(posedge clk);
        #1;
        check({tag, "_ack"}, 32'(code_ack), 32'(exp_ack));
        check({tag, "_err"}, 32'(entry_error), 32'(exp_err));
        check({tag, "_cnt"}, 32'(digit_count), 32'(exp_cnt));
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        entry_en  = 1'b1;
        key_valid = 1'b0;
        key       = 4'h0;
        idle(3);
        check("rst_code", 32'(code), 32'h0000);
        check("rst_ack", 32'(code_ack), 32'd0);
        check("rst_err", 32'(entry_error), 32'd0);
        check("rst_cnt", 32'(digit_count), 32'd0);
        rst = 1'b0;
        idle(1);

        // 5,9,9,0 enter -> 5990
        press("a5", 4'h5, 1'b0, 1'b0, 3'd1, 16'h0);
        press("a9", 4'h9, 1'b0, 1'b0, 3'd2, 16'h0);
        press("a9b", 4'h9, 1'b0, 1'b0, 3'd3, 16'h0);
        press("a0", 4'h0, 1'b0, 1'b0, 3'd4, 16'h0);
        press("a_ent", 4'hE, 1'b1, 1'b0, 3'd4, 16'h5990);
        idle(1);
        check("a_cnt_after", 32'(digit_count), 32'd0);
        check("a_code_hold", 32'(code), 32'h5990);

        // 1,2,3 enter -> short entry error, code held
        press("b1", 4'h1, 1'b0, 1'b0, 3'd1, 16'h0);
        press("b2", 4'h2, 1'b0, 1'b0, 3'd2, 16'h0);
        press("b3", 4'h3, 1'b0, 1'b0, 3'd3, 16'h0);
        press("b_ent", 4'hE, 1'b0, 1'b1, 3'd0, 16'h0);
        idle(1);
        check("b_code_hold", 32'(code), 32'h5990);

        // 1,2,3,4,7 enter -> error on fifth digit, then 1234
        press("c1", 4'h1, 1'b0, 1'b0, 3'd1, 16'h0);
        press("c2", 4'h2, 1'b0, 1'b0, 3'd2, 16'h0);
        press("c3", 4'h3, 1'b0, 1'b0, 3'd3, 16'h0);
        press("c4", 4'h4, 1'b0, 1'b0, 3'd4, 16'h0);
        press("c7", 4'h7, 1'b0, 1'b1, 3'd4, 16'h0);
        press("c_ent", 4'hE, 1'b1, 1'b0, 3'd4, 16'h1234);
        idle(1);
        check("c_cnt_after", 32'(digit_count), 32'd0);

        // ignored codes and clear key
        press("d6", 4'h6, 1'b0, 1'b0, 3'd1, 16'h0);
        press("d_a", 4'hA, 1'b0, 1'b0, 3'd1, 16'h0);
        press("d_f", 4'hF, 1'b0, 1'b0, 3'd1, 16'h0);
        press("d_clr", 4'hC, 1'b0, 1'b0, 3'd0, 16'h0);
        idle(1);

        // key 4 then idle -> timeout error after 8 cycles
        press("e4", 4'h4, 1'b0, 1'b0, 3'd1, 16'h0);
        expq.push_back({1'b0, last_code});
        got = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (entry_error) begin
                got = i;
                break;
            end
        end
        check("timeout_latency", 32'(got), 32'd8);
        @(negedge clk);
        check("timeout_cnt", 32'(digit_count), 32'd0);
        press("e5", 4'h5, 1'b0, 1'b0, 3'd1, 16'h0);
        press("e9", 4'h9, 1'b0, 1'b0, 3'd2, 16'h0);
        press("e9b", 4'h9, 1'b0, 1'b0, 3'd3, 16'h0);
        press("e0", 4'h0, 1'b0, 1'b0, 3'd4, 16'h0);
        press("e_ent", 4'hE, 1'b1, 1'b0, 3'd4, 16'h5990);
        idle(1);

        // reset mid-entry discards partial PIN
        press("f5", 4'h5, 1'b0, 1'b0, 3'd1, 16'h0);
        press("f9", 4'h9, 1'b0, 1'b0, 3'd2, 16'h0);
        rst = 1'b1;
        idle(2);
        check("f_rst_code", 32'(code), 32'h0000);
        check("f_rst_cnt", 32'(digit_count), 32'd0);
        rst = 1'b0;
        last_code = 16'h0000;
        press("f9b", 4'h9, 1'b0, 1'b0, 3'd1, 16'h0);
        press("f0", 4'h0, 1'b0, 1'b0, 3'd2, 16'h0);
        press("f_ent", 4'hE, 1'b0, 1'b1, 3'd0, 16'h0);
        idle(1);

        // entry_en drop after three digits
        press("g1", 4'h1, 1'b0, 1'b0, 3'd1, 16'h0);
        press("g2", 4'h2, 1'b0, 1'b0, 3'd2, 16'h0);
        press("g3", 4'h3, 1'b0, 1'b0, 3'd3, 16'h0);
        entry_en = 1'b0;
        idle(1);
        check("g_drop_cnt", 32'(digit_count), 32'd0);
        press("g7_off", 4'h7, 1'b0, 1'b0, 3'd0, 16'h0);
        entry_en = 1'b1;
        press("g5", 4'h5, 1'b0, 1'b0, 3'd1, 16'h0);
        press("g9", 4'h9, 1'b0, 1'b0, 3'd2, 16'h0);
        press("g9b", 4'h9, 1'b0, 1'b0, 3'd3, 16'h0);
        press("g0", 4'h0, 1'b0, 1'b0, 3'd4, 16'h0);
        press("g_ent", 4'hE, 1'b1, 1'b0, 3'd4, 16'h5990);
        idle(3);

        check("queue_drained", 32'(expq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
